// File: rtl/vga_pkg.sv
// vga_pkg
//   Shared constants for the 640x480 VGA scan path.
//   - default horizontal/vertical timing in pixels/lines plus the derived totals
//   - colour bit positions inside the 3-bit colour word (R=2, G=1, B=0)
//   - function codes understood by the downstream colour-selection stage
//   - widths of the row/column fields packed into display_addr
package vga_pkg;

  localparam int DEF_H_ACTIVE  = 640;
  localparam int DEF_H_FP      = 16;
  localparam int DEF_H_SYNC    = 96;
  localparam int DEF_H_BP      = 48;
  localparam int DEF_V_ACTIVE  = 480;
  localparam int DEF_V_FP      = 10;
  localparam int DEF_V_SYNC    = 2;
  localparam int DEF_V_BP      = 33;
  localparam int DEF_COLOR_LAT = 1;

  localparam int H_TOTAL = DEF_H_ACTIVE + DEF_H_FP + DEF_H_SYNC + DEF_H_BP;
  localparam int V_TOTAL = DEF_V_ACTIVE + DEF_V_FP + DEF_V_SYNC + DEF_V_BP;

  localparam int COLOR_R = 2;
  localparam int COLOR_G = 1;
  localparam int COLOR_B = 0;

  typedef enum logic [1:0] {
    FUNC_VRAM = 2'd0,
    FUNC_GPU  = 2'd1,
    FUNC_ALT  = 2'd2
  } func_e;

  localparam int COL_W  = 10;
  localparam int ROW_W  = 10;
  localparam int ADDR_W = ROW_W + COL_W;

endpackage

// File: rtl/vga_delay_line.sv
// vga_delay_line
//   WIDTH x DEPTH shift register with synchronous clear to CLEAR_VAL.
//   DEPTH = 0 degenerates to a plain wire from din to dout.
// Ports:
//   clk   in         clock
//   rst   in         synchronous active-high clear (all stages <= CLEAR_VAL)
//   din   in  WIDTH  data entering the line
//   dout  out WIDTH  data delayed by DEPTH cycles
module vga_delay_line #(
  parameter int              WIDTH     = 3,
  parameter int              DEPTH     = 1,
  parameter logic [WIDTH-1:0] CLEAR_VAL = '0
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] din,
  output logic [WIDTH-1:0] dout
);

  generate
    if (DEPTH == 0) begin : g_pass
      assign dout = din;
    end else begin : g_shift
      logic [WIDTH-1:0] stages [DEPTH];

      // Clearing to CLEAR_VAL rather than zero lets the caller choose the
      // idle level of each bit, so active-low syncs stay deasserted.
      always_ff @(posedge clk) begin
        if (rst) begin
          for (int i = 0; i < DEPTH; i++) stages[i] <= CLEAR_VAL;
        end else begin
          stages[0] <= din;
          for (int i = 1; i < DEPTH; i++) stages[i] <= stages[i-1];
        end
      end

      assign dout = stages[DEPTH-1];
    end
  endgenerate

endmodule

// File: rtl/vga_scan_timer.sv
// vga_scan_timer
//   Pixel-clock scan generator: walks h/v counters, issues display_addr to the
//   colour-selection stage, blanks the returned colour and drives RGB/sync pins
//   with every signal aligned to the same pixel (counter -> pins = COLOR_LAT+2).
//   current_function is latched only when the scan enters vertical blanking.
//   Optional feature macro: VGA_TEST_PATTERN_EN (adds test_pattern input that
//   replaces display_color with 64-pixel colour bars taken from col[8:6]).
// Ports:
//   clk               in   pixel clock
//   rst               in   synchronous active-high reset
//   func_req          in 2 requested function code
//   display_color     in 3 colour for the address issued COLOR_LAT cycles ago
//   test_pattern      in   (VGA_TEST_PATTERN_EN only) select colour bars
//   display_addr      out 20 {row, col} during active video, 0 in blanking
//   current_function  out 2 frame-stable function code
//   frame_start       out   one-cycle pulse with display_addr for (0,0)
//   vga_hsync/vsync   out   active-low syncs
//   vga_r/g/b         out   pin colour
module vga_scan_timer
  import vga_pkg::*;
#(
  parameter int H_ACTIVE  = DEF_H_ACTIVE,
  parameter int H_FP      = DEF_H_FP,
  parameter int H_SYNC    = DEF_H_SYNC,
  parameter int H_BP      = DEF_H_BP,
  parameter int V_ACTIVE  = DEF_V_ACTIVE,
  parameter int V_FP      = DEF_V_FP,
  parameter int V_SYNC    = DEF_V_SYNC,
  parameter int V_BP      = DEF_V_BP,
  parameter int COLOR_LAT = DEF_COLOR_LAT
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [1:0]        func_req,
  input  logic [2:0]        display_color,
`ifdef VGA_TEST_PATTERN_EN
  input  logic              test_pattern,
`endif
  output logic [ADDR_W-1:0] display_addr,
  output logic [1:0]        current_function,
  output logic              frame_start,
  output logic              vga_hsync,
  output logic              vga_vsync,
  output logic              vga_r,
  output logic              vga_g,
  output logic              vga_b
);

  localparam int H_TOT = H_ACTIVE + H_FP + H_SYNC + H_BP;
  localparam int V_TOT = V_ACTIVE + V_FP + V_SYNC + V_BP;

  localparam logic [COL_W-1:0] H_LAST   = COL_W'(H_TOT - 1);
  localparam logic [ROW_W-1:0] V_LAST   = ROW_W'(V_TOT - 1);
  localparam logic [COL_W-1:0] H_ACT_C  = COL_W'(H_ACTIVE);
  localparam logic [ROW_W-1:0] V_ACT_C  = ROW_W'(V_ACTIVE);
  localparam logic [ROW_W-1:0] V_ACT_M1 = ROW_W'(V_ACTIVE - 1);
  localparam logic [COL_W-1:0] HS_START = COL_W'(H_ACTIVE + H_FP);
  localparam logic [COL_W-1:0] HS_END   = COL_W'(H_ACTIVE + H_FP + H_SYNC);
  localparam logic [ROW_W-1:0] VS_START = ROW_W'(V_ACTIVE + V_FP);
  localparam logic [ROW_W-1:0] VS_END   = ROW_W'(V_ACTIVE + V_FP + V_SYNC);

`ifdef VGA_TEST_PATTERN_EN
  localparam int               DL_W     = 7;
  localparam logic [DL_W-1:0]  DL_CLEAR = 7'b011_0_000;
`else
  localparam int               DL_W     = 3;
  localparam logic [DL_W-1:0]  DL_CLEAR = 3'b011;
`endif

  logic [COL_W-1:0] h_cnt;
  logic [ROW_W-1:0] v_cnt;
  logic             h_last;
  logic             v_last;
  logic             active_0, hs_0, vs_0;
  logic             active_1, hs_1, vs_1;
  logic             active_d, hs_d, vs_d;
  logic [DL_W-1:0]  dl_in, dl_out;
  logic [2:0]       pix_color;

  assign h_last = (h_cnt == H_LAST);
  assign v_last = (v_cnt == V_LAST);

  // Raster counters; v advances only when h wraps, both wrap together.
  always_ff @(posedge clk) begin
    if (rst) begin
      h_cnt <= '0;
      v_cnt <= '0;
    end else if (h_last) begin
      h_cnt <= '0;
      v_cnt <= v_last ? '0 : v_cnt + 1'b1;
    end else begin
      h_cnt <= h_cnt + 1'b1;
    end
  end

  assign active_0 = (h_cnt < H_ACT_C) && (v_cnt < V_ACT_C);
  assign hs_0     = !((h_cnt >= HS_START) && (h_cnt < HS_END));
  assign vs_0     = !((v_cnt >= VS_START) && (v_cnt < VS_END));

  // Stage 1: the address and its matching control bits leave together.
  always_ff @(posedge clk) begin
    if (rst) begin
      display_addr <= '0;
      active_1     <= 1'b0;
      hs_1         <= 1'b1;
      vs_1         <= 1'b1;
      frame_start  <= 1'b0;
    end else begin
      display_addr <= active_0 ? {v_cnt, h_cnt} : '0;
      active_1     <= active_0;
      hs_1         <= hs_0;
      vs_1         <= vs_0;
      frame_start  <= (h_cnt == '0) && (v_cnt == '0);
    end
  end

  // Latch the function on the edge that moves the scan to (0, V_ACTIVE),
  // i.e. the first cycle of vertical blanking, so a frame never tears.
  always_ff @(posedge clk) begin
    if (rst) begin
      current_function <= FUNC_VRAM;
    end else if (h_last && (v_cnt == V_ACT_M1)) begin
      current_function <= func_req;
    end
  end

`ifdef VGA_TEST_PATTERN_EN
  logic       tp_sel_1, tp_sel_d;
  logic [2:0] tp_color_1, tp_color_d;

  // Bar colour is sampled in stage 1 so it rides the same delay line as
  // the sync/active bits and lands on the pixel it was computed for.
  always_ff @(posedge clk) begin
    if (rst) begin
      tp_sel_1   <= 1'b0;
      tp_color_1 <= 3'b000;
    end else begin
      tp_sel_1   <= test_pattern;
      tp_color_1 <= h_cnt[8:6];
    end
  end

  assign dl_in = {active_1, hs_1, vs_1, tp_sel_1, tp_color_1};
  assign {active_d, hs_d, vs_d, tp_sel_d, tp_color_d} = dl_out;
  assign pix_color = tp_sel_d ? tp_color_d : display_color;
`else
  assign dl_in = {active_1, hs_1, vs_1};
  assign {active_d, hs_d, vs_d} = dl_out;
  assign pix_color = display_color;
`endif

  vga_delay_line #(
    .WIDTH     (DL_W),
    .DEPTH     (COLOR_LAT),
    .CLEAR_VAL (DL_CLEAR)
  ) u_delay (
    .clk  (clk),
    .rst  (rst),
    .din  (dl_in),
    .dout (dl_out)
  );

  // Output register: the delayed active bit blanks the returned colour,
  // so RGB and syncs always describe the same pixel.
  always_ff @(posedge clk) begin
    if (rst) begin
      vga_hsync <= 1'b1;
      vga_vsync <= 1'b1;
      vga_r     <= 1'b0;
      vga_g     <= 1'b0;
      vga_b     <= 1'b0;
    end else begin
      vga_hsync <= hs_d;
      vga_vsync <= vs_d;
      vga_r     <= active_d & pix_color[COLOR_R];
      vga_g     <= active_d & pix_color[COLOR_G];
      vga_b     <= active_d & pix_color[COLOR_B];
    end
  end

endmodule
